// File: rtl/bemicro_cv_button_pio.sv
// ----------------------------------------------------------------------------
// bemicro_cv_button_pio
//
// Avalon-MM slave input PIO for the board push-buttons and switches. Each pad
// is synchronised (2 flops), debounced (per-bit stable-cycle counter), and
// edge-detected into a write-1-to-clear capture register. A registered level
// interrupt is raised while any captured edge is enabled by the mask.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     Avalon word address (0 data, 1 reserved, 2 mask, 3 capture)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   in_port     raw asynchronous pad inputs
//   readdata    registered read data, latency 1
//   irq         level interrupt, active high
// ----------------------------------------------------------------------------
module bemicro_cv_button_pio #(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = {WIDTH{1'b1}},
    parameter int unsigned      EDGE_TYPE       = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned      CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] deb_q;
    logic [WIDTH-1:0] deb_d;
    logic [WIDTH-1:0] deb_dly_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] cap_d;
    logic [WIDTH-1:0] edge_hit;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic             irq_q;
    logic             irq_d;
    logic             wr_en;
    logic             rd_en;
    logic             unused_wdata;

    assign wr_en = chipselect & ~write_n;
    assign rd_en = chipselect &  write_n;

    // Only the low WIDTH bits of writedata are meaningful.
    assign unused_wdata = ^{1'b0, writedata};

    // Per-bit debounce: the counter only runs while synced and debounced
    // disagree, so any return to agreement restarts the stability window.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        case (EDGE_TYPE)
            0:       edge_hit =  deb_q & ~deb_dly_q;
            1:       edge_hit = ~deb_q &  deb_dly_q;
            default: edge_hit =  deb_q ^  deb_dly_q;
        endcase
    end

    // Edge set is OR-ed after the W1C so a coincident edge survives the clear.
    always_comb begin
        mask_d = mask_q;
        cap_d  = cap_q;
        if (wr_en && address == 2'd2) begin
            mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == 2'd3) begin
            cap_d = cap_q & ~writedata[WIDTH-1:0];
        end
        cap_d = cap_d | edge_hit;
    end

    // Reads sample the current (pre-update) register values.
    always_comb begin
        readdata_d = readdata_q;
        if (rd_en) begin
            readdata_d = '0;
            case (address)
                2'd0:    readdata_d[WIDTH-1:0] = deb_q;
                2'd2:    readdata_d[WIDTH-1:0] = mask_q;
                2'd3:    readdata_d[WIDTH-1:0] = cap_q;
                default: readdata_d = '0;
            endcase
        end
    end

    assign irq_d = |(cap_q & mask_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= RESET_LEVEL;
            sync2_q    <= RESET_LEVEL;
            deb_q      <= RESET_LEVEL;
            deb_dly_q  <= RESET_LEVEL;
            mask_q     <= '0;
            cap_q      <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_dly_q  <= deb_q;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_bemicro_cv_button_pio.sv
// ----------------------------------------------------------------------------
// tb_bemicro_cv_button_pio
//
// Bench for bemicro_cv_button_pio (WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=1).
// Inputs are driven and outputs sampled on the falling clock edge. Each read
// pushes its expected readdata; a monitor pops and compares once the read's
// data is returned.
// ----------------------------------------------------------------------------
module tb_bemicro_cv_button_pio;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q [$];
    logic        rd_acc;

    always #5 clk = ~clk;

    bemicro_cv_button_pio #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4),
        .RESET_LEVEL     (4'hF),
        .EDGE_TYPE       (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp);
        address    = a;
        write_n    = 1'b1;
        chipselect = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        chipselect = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        write_n    = 1'b0;
        chipselect = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Marks cycles whose posedge accepted a read.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_acc <= 1'b0;
        else          rd_acc <= chipselect & write_n;
    end

    always @(negedge clk) begin
        if (rd_acc) begin
            if (exp_q.size() == 0) begin
                check("rd_sb_nonempty", 32'(exp_q.size()), 32'd1);
            end else begin
                check("rd_data", readdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;
        repeat (2) tick();
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        repeat (8) begin
            tick();
            check("post_rst_irq", {31'b0, irq}, 32'h0);
        end
        bus_read(2'd0, 32'h0000_000F);
        bus_read(2'd3, 32'h0);

        // 3-cycle glitch on bit 0 must be filtered
        in_port = 4'hE;
        repeat (3) tick();
        in_port = 4'hF;
        repeat (8) bus_read(2'd0, 32'h0000_000F);
        bus_read(2'd3, 32'h0);

        // Sustained press: debounced change lands on the 6th posedge
        in_port = 4'hE;
        for (int j = 1; j <= 10; j++) begin
            bus_read(2'd0, (j <= 6) ? 32'h0000_000F : 32'h0000_000E);
        end
        bus_read(2'd3, 32'h1);

        // Mask enable then W1C
        bus_write(2'd2, 32'h1);
        check("irq_mask_wr_0", {31'b0, irq}, 32'h0);
        tick();
        check("irq_mask_wr_1", {31'b0, irq}, 32'h1);
        bus_write(2'd3, 32'h1);
        check("irq_w1c_0", {31'b0, irq}, 32'h1);
        tick();
        check("irq_w1c_1", {31'b0, irq}, 32'h0);
        bus_read(2'd3, 32'h0);

        // Capture of bit 2 coincides with W1C of bit 2: set wins
        in_port = 4'hA;
        repeat (6) tick();
        bus_write(2'd3, 32'h4);
        bus_read(2'd3, 32'h4);
        check("irq_masked_b2", {31'b0, irq}, 32'h0);
        bus_write(2'd3, 32'h4);
        bus_read(2'd3, 32'h0);

        // Masked edge on bit 3, then enable
        bus_write(2'd2, 32'h0);
        in_port = 4'h2;
        repeat (10) begin
            tick();
            check("irq_masked_b3", {31'b0, irq}, 32'h0);
        end
        bus_read(2'd3, 32'h8);
        bus_read(2'd2, 32'h0);
        bus_write(2'd2, 32'h8);
        check("irq_b3_0", {31'b0, irq}, 32'h0);
        tick();
        check("irq_b3_1", {31'b0, irq}, 32'h1);
        bus_read(2'd1, 32'h0);
        bus_read(2'd2, 32'h8);

        // Asynchronous reset mid-debounce of bit 1
        in_port = 4'h0;
        repeat (2) tick();
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_readdata", readdata, 32'h0);
        check("async_rst_irq", {31'b0, irq}, 32'h0);
        in_port = 4'hF;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (10) begin
            tick();
            check("rerst_irq", {31'b0, irq}, 32'h0);
        end
        bus_read(2'd3, 32'h0);
        bus_read(2'd0, 32'h0000_000F);
        bus_read(2'd2, 32'h0);
        tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bemicro_cv_button_pio.md
Name: bemicro_cv_button_pio

Overview:
- Avalon-MM slave input PIO. It samples the board push-buttons and switches, synchronises and debounces them, and latches edges into a capture register.
- Raises a level interrupt to the Nios II core.
- It is the read-side counterpart of the LED output PIO and sits on the same system interconnect, with the same address map style.

Parameters:
- WIDTH, 4, number of input bits (1..32)
- DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles required before a debounced bit changes (1 ms at 50 MHz); must be >= 1
- RESET_LEVEL, {WIDTH{1'b1}}, debounced value loaded at reset (buttons are active-low with pull-ups)
- EDGE_TYPE, 1, edge that sets a capture bit: 0 = rising, 1 = falling, 2 = any

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset (see Behaviour)
- address  in  2  Avalon word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  WIDTH  raw asynchronous pad inputs
- readdata  out  32  read data, valid 1 cycle after the read is accepted
- irq  out  1  level interrupt, active high

Behaviour:
- Reset: reset_n, asynchronous, active-low; clock clk.
- Values on reset:
  - synchroniser flops = RESET_LEVEL
  - debounced = RESET_LEVEL
  - debounce counters = 0
  - irq_mask = 0
  - edge_capture = 0
  - readdata = 0
  - irq = 0
- Synchroniser: 2-flop chain per bit on in_port. Only the second stage feeds downstream logic.
- Debounce (per bit, independent):
  - While the synchronised bit equals the debounced bit, the counter clears to 0.
  - Otherwise the counter increments each cycle.
  - When counter == DEBOUNCE_CYCLES-1 and the bits still differ, the debounced bit takes the synced value on that edge and the counter clears.
  - Counter width: clog2(DEBOUNCE_CYCLES)+1; it never wraps.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
  - Total latency from a pad change to the debounced change = 2 + DEBOUNCE_CYCLES cycles.
- Edge detect: compare debounced against its 1-cycle delayed copy. The delayed copy resets to RESET_LEVEL, so reset never creates an edge.
  - A detected edge per EDGE_TYPE sets its edge_capture bit on the next clk.
- Register map (word addresses):
  - 0, data: R = zero-extended debounced value; writes ignored.
  - 1: reserved; reads 0, writes ignored.
  - 2, irq_mask: R/W, bits [WIDTH-1:0]; upper bits read 0.
  - 3, edge_capture: R; a write clears each bit where writedata[i] = 1 (write-1-to-clear).
- Write accepted: chipselect & ~write_n. Read accepted: chipselect & write_n.
- readdata is registered, read latency 1, no wait states. Outside reads, readdata holds its last value.
- Simultaneous events:
  - An edge and a W1C on the same bit in the same cycle leaves the bit set (set wins).
  - A read of address 3 in the same cycle as a new edge returns the pre-edge value. The edge is visible on the next read.
- irq = |(edge_capture & irq_mask), registered, so it asserts 1 cycle after the capture bit sets. It deasserts 1 cycle after a clear or mask write removes the last enabled bit.
- Reset mid-debounce or mid-read: all state returns to reset values immediately. A pending read returns 0.
- WIDTH < 32: bits above WIDTH-1 of readdata are always 0.

Test Plan (bench uses WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=1):
- Reset with in_port=4'hF, then read addr 0 -> readdata=32'h0000000F. edge_capture=0 and irq=0 throughout, with no spurious edge.
- Drive in_port[0] low for 3 cycles, then high -> debounced stays 4'hF and addr 3 reads 0. Then hold bit 0 low for 10 cycles -> addr 0 reads 4'hE. The debounced change occurs exactly 6 cycles after the pad change. addr 3 reads 32'h1.
- Write addr 2 = 32'h1 with edge_capture[0] already set -> irq rises 1 cycle after the write. Write addr 3 = 32'h1 -> edge_capture=0 and irq falls 1 cycle later.
- Falling edge on bit 2 timed so the capture lands in the same cycle as a W1C of addr 3 with writedata=32'h4 -> edge_capture[2] remains 1, and the next read of addr 3 returns 32'h4.
- Mask=0 with a falling edge on bit 3 -> edge_capture=32'h8 and irq stays 0. Write mask=32'h8 -> irq=1 one cycle later.
- Assert reset_n low mid-debounce with bit 1 pressed for 2 cycles -> all outputs go to 0 asynchronously. After release with in_port=4'hF, no edge is captured.
